// File: rtl/model_out_capture.sv
// ---------------------------------------------------------------------------
// model_out_capture
//   Capture stage for the `model` cell output buses o0[2:-2] and o1[-2:2].
//   Each valid/ready transfer pushes one {o0,o1} pair into a DEPTH-entry
//   FIFO. The head entry is presented to the consumer. Declared index
//   ranges are kept, so bit k of an input always lands on bit k of the
//   output. There is no combinational path from in_* to out_*.
//
//   Optional feature macro: MODEL_OUT_CAPTURE_PARITY_EN
//     When defined, each entry also stores the even parity of {in_o0,in_o1}.
//     That bit is presented on out_par.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   flush      synchronous clear of pointers and count (beats push/pop)
//   in_valid   producer has a pair on in_o0/in_o1
//   in_ready   stage can accept (= !full)
//   in_o0      model o0 bus, [2:-2]
//   in_o1      model o1 bus, [-2:2]
//   out_valid  head entry available (= !empty)
//   out_ready  consumer takes head entry
//   out_o0     head entry o0, [2:-2], zero while empty
//   out_o1     head entry o1, [-2:2], zero while empty
//   out_par    (parity build only) stored parity of head, zero while empty
//   count      occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module model_out_capture #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:-2]   in_o0,
    input  logic [-2:2]   in_o1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:-2]   out_o0,
    output logic [-2:2]   out_o1,
`ifdef MODEL_OUT_CAPTURE_PARITY_EN
    output logic          out_par,
`endif
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Storage keeps the declared ranges, so whole-vector copies are
    // index-for-index with no reversal.
    logic [2:-2]   mem_o0 [DEPTH];
    logic [-2:2]   mem_o1 [DEPTH];
`ifdef MODEL_OUT_CAPTURE_PARITY_EN
    logic          mem_par [DEPTH];
`endif

    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally not reset. Writes are suppressed on flush,
    // so dropped data never lands in the array.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_o0[wr_ptr] <= in_o0;
            mem_o1[wr_ptr] <= in_o1;
`ifdef MODEL_OUT_CAPTURE_PARITY_EN
            mem_par[wr_ptr] <= ^{in_o0, in_o1};
`endif
        end
    end

    assign out_o0 = out_valid ? mem_o0[rd_ptr] : '0;
    assign out_o1 = out_valid ? mem_o1[rd_ptr] : '0;
`ifdef MODEL_OUT_CAPTURE_PARITY_EN
    assign out_par = out_valid & mem_par[rd_ptr];
`endif

endmodule

// File: tb/tb_model_out_capture.sv
// ---------------------------------------------------------------------------
// tb_model_out_capture
//   Directed self-checking bench for model_out_capture (DEPTH=4, AW=2).
//   Inputs change 1ns after a rising edge, and outputs are sampled there.
//   Define MODEL_OUT_CAPTURE_PARITY_EN to build and check the parity port.
// ---------------------------------------------------------------------------
module tb_model_out_capture;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:-2] in_o0;
    logic [-2:2] in_o1;
    logic        out_valid;
    logic        out_ready;
    logic [2:-2] out_o0;
    logic [-2:2] out_o1;
    logic [2:0]  count;
`ifdef MODEL_OUT_CAPTURE_PARITY_EN
    logic        out_par;
`endif

    int checks;
    int errors;

    model_out_capture #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_o0     (in_o0),
        .in_o1     (in_o1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_o0    (out_o0),
        .out_o1    (out_o1),
`ifdef MODEL_OUT_CAPTURE_PARITY_EN
        .out_par   (out_par),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] d0(input int i);
        return 5'(i * 7 + 3);
    endfunction

    function automatic logic [4:0] d1(input int i);
        return 5'(i * 11 + 5);
    endfunction

    initial begin
        logic [4:0] v;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_o0     = '0;
        in_o1     = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check_val("rst_count",     32'(count),     32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_in_ready",  32'(in_ready),  32'd1);
        check_val("rst_out_o0",    32'(out_o0),    32'd0);
        check_val("rst_out_o1",    32'(out_o1),    32'd0);

        // Empty: out_ready ignored, no underflow
        out_ready = 1'b1;
        step();
        check_val("empty_pop_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Bit mapping by index
        in_valid = 1'b1;
        in_o0    = 5'b10010;
        in_o1    = 5'b00111;
        check_val("no_bypass_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check_val("map_count",     32'(count),      32'd1);
        check_val("map_valid",     32'(out_valid),  32'd1);
        check_val("map_o0_2",      32'(out_o0[2]),  32'd1);
        check_val("map_o0_m1",     32'(out_o0[-1]), 32'd1);
        check_val("map_o0_0",      32'(out_o0[0]),  32'd0);
        check_val("map_o1_m2",     32'(out_o1[-2]), 32'd0);
        check_val("map_o1_2",      32'(out_o1[2]),  32'd1);
        check_val("map_o1_0",      32'(out_o1[0]),  32'd1);
        check_val("map_o0_vec",    32'(out_o0),     32'h12);
        check_val("map_o1_vec",    32'(out_o1),     32'h07);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("map_pop_count", 32'(count),  32'd0);
        check_val("map_pop_o0",    32'(out_o0), 32'd0);

        // Fill to full with out_ready=0
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            v        = 5'(1 << i);
            in_o0    = v;
            in_o1    = ~v;
            step();
        end
        check_val("fill_count",    32'(count),    32'd4);
        check_val("fill_in_ready", 32'(in_ready), 32'd0);
        in_o0 = 5'h1F;
        in_o1 = 5'h1F;
        step();
        check_val("fill_5th_count", 32'(count),  32'd4);
        check_val("fill_head",      32'(out_o0), 32'h01);
        // Pop at full while still offering data: in_ready is 0, so nothing is pushed.
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("full_pop_count",    32'(count),    32'd3);
        check_val("full_pop_in_ready", 32'(in_ready), 32'd1);
        check_val("full_pop_head",     32'(out_o0),   32'h02);
        check_val("full_pop_head_o1",  32'(out_o1),   32'h1D);
        out_ready = 1'b1;
        step();
        check_val("drain_c", 32'(out_o0), 32'h04);
        step();
        check_val("drain_d", 32'(out_o0), 32'h08);
        step();
        check_val("drain_empty", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Simultaneous push/pop at count=2, across pointer wrap
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_o0 = d0(i);
            in_o1 = d1(i);
            step();
        end
        check_val("pp_start_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_o0 = d0(k + 2);
            in_o1 = d1(k + 2);
            step();
            check_val($sformatf("pp_count_%0d", k), 32'(count),  32'd2);
            check_val($sformatf("pp_o0_%0d", k),    32'(out_o0), 32'(d0(k + 1)));
            check_val($sformatf("pp_o1_%0d", k),    32'(out_o1), 32'(d1(k + 1)));
        end

        // Grow to 3 entries, then flush with simultaneous push and pop
        out_ready = 1'b0;
        in_o0     = d0(12);
        in_o1     = d1(12);
        step();
        check_val("pre_flush_count", 32'(count), 32'd3);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_o0     = 5'h15;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("flush_count", 32'(count),     32'd0);
        check_val("flush_valid", 32'(out_valid), 32'd0);
        check_val("flush_o0",    32'(out_o0),    32'd0);

        // Post-flush push goes to slot 0 and is read back correctly
        in_valid = 1'b1;
        in_o0    = 5'h0B;
        in_o1    = 5'h16;
        step();
        in_valid = 1'b0;
        check_val("post_flush_o0", 32'(out_o0), 32'h0B);
        check_val("post_flush_o1", 32'(out_o1), 32'h16);

        // Asynchronous reset mid-cycle while a push is offered
        in_valid = 1'b1;
        in_o0    = 5'h1C;
        step();
        check_val("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_count",    32'(count),     32'd0);
        check_val("async_rst_valid",    32'(out_valid), 32'd0);
        check_val("async_rst_in_ready", 32'(in_ready),  32'd1);
        check_val("async_rst_o0",       32'(out_o0),    32'd0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check_val("post_rst_count", 32'(count), 32'd0);

`ifdef MODEL_OUT_CAPTURE_PARITY_EN
        check_val("par_empty", 32'(out_par), 32'd0);
        in_valid = 1'b1;
        in_o0    = 5'b00001;
        in_o1    = 5'b00000;
        step();
        in_o0 = 5'b00011;
        step();
        in_valid = 1'b0;
        check_val("par_one", 32'(out_par), 32'd1);
        out_ready = 1'b1;
        step();
        check_val("par_zero", 32'(out_par), 32'd0);
        step();
        out_ready = 1'b0;
        check_val("par_drained", 32'(out_par), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
